// File: rtl/pdm_mic_frontend_if.sv
`default_nettype none
// ============================================================================
// pdm_mic_frontend_if : PCM output bundle of the PDM microphone front end.
// Revision 1.0
// ============================================================================
interface pdm_mic_frontend_if #(
   parameter int NUM_CH    = 1,
   parameter int OUT_WIDTH = 16
);
   logic                          pdm_tick_out;
   logic [NUM_CH-1:0]             pdm_bits_out;
   logic                          sample_valid_out;
   logic [NUM_CH*OUT_WIDTH-1:0]   sample_out;

   modport master (
      output pdm_tick_out,
      output pdm_bits_out,
      output sample_valid_out,
      output sample_out
   );

   modport slave (
      input  pdm_tick_out,
      input  pdm_bits_out,
      input  sample_valid_out,
      input  sample_out
   );
endinterface
`default_nettype wire

// File: rtl/pdm_mic_frontend.sv
`default_nettype none
// ============================================================================
// pdm_mic_frontend : mic clock generation, per-channel PDM capture and boxcar
// decimation to signed PCM. Optional DC blocker: define PDM_FE_DCBLOCK_EN.
// Revision 1.0
// ============================================================================
module pdm_mic_frontend #(
   parameter int CLK_DIV   = 32,
   parameter int DECIM     = 256,
   parameter int OUT_WIDTH = 16,
   parameter int NUM_CH    = 1
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               enable_in,
   input  logic               mic_data_in,
   output logic               mic_clk_out,
   pdm_mic_frontend_if.master pcm
);
   localparam int LOG2D = $clog2(DECIM);
   localparam int SW    = LOG2D + 1;
   localparam int CW    = $clog2(CLK_DIV);

   localparam logic [CW-1:0]    CNT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0]    CNT_CH0   = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0]    CNT_HALF  = CW'(CLK_DIV / 2);
   localparam logic [LOG2D-1:0] TICK_LAST = LOG2D'(DECIM - 1);
   localparam logic [SW-1:0]    DECIM_SW  = SW'(DECIM);

   logic [CW-1:0]                     cnt_q;
   logic                              mic_clk_q;
   logic                              wrap_q;
   logic                              tick_q;
   logic                              valid_q;
   logic [NUM_CH-1:0]                 smp_q;
   logic [NUM_CH-1:0]                 bits_q;
   logic [LOG2D-1:0]                  tick_cnt_q;
   logic [NUM_CH-1:0][SW-1:0]         tally_q;
   logic [NUM_CH-1:0][OUT_WIDTH-1:0]  aligned;
   logic [NUM_CH-1:0][OUT_WIDTH-1:0]  sample_q;
   logic                              close;

   // Gating with enable_in discards a frame whose closing tick meets a disable.
   assign close = tick_q && enable_in && (tick_cnt_q == TICK_LAST);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cnt_q      <= '0;
         mic_clk_q  <= 1'b0;
         wrap_q     <= 1'b0;
         tick_q     <= 1'b0;
         smp_q      <= '0;
         bits_q     <= '0;
         tick_cnt_q <= '0;
         tally_q    <= '0;
      end else if (!enable_in) begin
         cnt_q      <= '0;
         mic_clk_q  <= 1'b0;
         wrap_q     <= 1'b0;
         tick_q     <= 1'b0;
         tick_cnt_q <= '0;
         tally_q    <= '0;
      end else begin
         cnt_q     <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
         mic_clk_q <= (cnt_q < CNT_HALF);
         wrap_q    <= (cnt_q == CNT_LAST);
         tick_q    <= wrap_q;
         if (wrap_q)
            bits_q <= smp_q;
         if (cnt_q == CNT_CH0)
            smp_q[0] <= mic_data_in;
         if (NUM_CH == 2 && cnt_q == CNT_LAST)
            smp_q[NUM_CH-1] <= mic_data_in;
         if (tick_q) begin
            tick_cnt_q <= close ? '0 : tick_cnt_q + 1'b1;
            for (int c = 0; c < NUM_CH; c++)
               tally_q[c] <= close ? '0 : tally_q[c] + SW'(bits_q[c]);
         end
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [SW-1:0]        total;
      logic signed [SW-1:0] s;

      // total only reaches its top bit when every bit of the frame was 1.
      assign total = tally_q[c] + SW'(bits_q[c]);
      assign s     = total[SW-1] ? {1'b0, {LOG2D{1'b1}}}
                                 : ({total[SW-2:0], 1'b0} - DECIM_SW);

      if (OUT_WIDTH >= SW) begin : g_shl
         logic signed [OUT_WIDTH-1:0] ext;
         assign ext        = OUT_WIDTH'(s);
         assign aligned[c] = ext << (OUT_WIDTH - SW);
      end else begin : g_shr
         assign aligned[c] = OUT_WIDTH'(s >>> (SW - OUT_WIDTH));
      end
   end

`ifdef PDM_FE_DCBLOCK_EN
   localparam int IW = OUT_WIDTH + 2;
   localparam logic signed [IW-1:0] YMAX = {3'b000, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [IW-1:0] YMIN = {3'b111, {(OUT_WIDTH-1){1'b0}}};

   logic [NUM_CH-1:0][OUT_WIDTH-1:0] x_q;
   logic [NUM_CH-1:0][OUT_WIDTH-1:0] xp_q;
   logic [NUM_CH-1:0][OUT_WIDTH-1:0] yp_q;
   logic [NUM_CH-1:0][OUT_WIDTH-1:0] y_sat;
   logic                             x_vld_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_dc
      logic signed [IW-1:0] y_wide;
      assign y_wide = IW'($signed(x_q[c])) - IW'($signed(xp_q[c]))
                    + IW'($signed(yp_q[c])) - IW'($signed(yp_q[c]) >>> 10);
      assign y_sat[c] = (y_wide > YMAX) ? YMAX[OUT_WIDTH-1:0] :
                        (y_wide < YMIN) ? YMIN[OUT_WIDTH-1:0] :
                                          y_wide[OUT_WIDTH-1:0];
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         x_q      <= '0;
         xp_q     <= '0;
         yp_q     <= '0;
         x_vld_q  <= 1'b0;
         valid_q  <= 1'b0;
         sample_q <= '0;
      end else if (!enable_in) begin
         xp_q     <= '0;
         yp_q     <= '0;
         x_vld_q  <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         x_vld_q <= close;
         valid_q <= x_vld_q;
         if (close)
            x_q <= aligned;
         if (x_vld_q) begin
            sample_q <= y_sat;
            xp_q     <= x_q;
            yp_q     <= y_sat;
         end
      end
   end
`else
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid_q  <= 1'b0;
         sample_q <= '0;
      end else begin
         valid_q <= close;
         if (close)
            sample_q <= aligned;
      end
   end
`endif

   assign mic_clk_out          = mic_clk_q;
   assign pcm.pdm_tick_out     = tick_q;
   assign pcm.pdm_bits_out     = bits_q;
   assign pcm.sample_valid_out = valid_q;
   assign pcm.sample_out       = sample_q;

endmodule
`default_nettype wire

// File: tb/tb_pdm_mic_frontend.sv
`default_nettype none
// ============================================================================
// tb_pdm_mic_frontend : scoreboard bench for mono, stereo and small-ratio builds.
// Revision 1.0
// ============================================================================
module tb_pdm_mic_frontend;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [15:0] exp_a(input int t);
      int s;
      s = 2 * t - 256;
      if (s > 255) s = 255;
      return 16'(s * 128);
   endfunction

   function automatic logic [7:0] exp_c(input int t);
      int s;
      s = 2 * t - 4;
      if (s > 3) s = 3;
      return 8'(s * 32);
   endfunction

   // ---------------- DUT A: defaults, mono ----------------
   logic rst_a = 1'b1, en_a = 1'b0, mclk_a;
   int   a_mode = 1;
   logic a_alt = 1'b1;
   wire  data_a = (a_mode == 2) ? a_alt : (a_mode == 1);
   pdm_mic_frontend_if #(.NUM_CH(1), .OUT_WIDTH(16)) if_a ();
   pdm_mic_frontend #(.CLK_DIV(32), .DECIM(256), .OUT_WIDTH(16), .NUM_CH(1)) u_a (
      .clk_in(clk), .rst_in(rst_a), .enable_in(en_a), .mic_data_in(data_a),
      .mic_clk_out(mclk_a), .pcm(if_a));

   // ---------------- DUT B: defaults, stereo ----------------
   logic rst_bc = 1'b1, en_b = 1'b0, mclk_b;
   wire  data_b = mclk_b;
   pdm_mic_frontend_if #(.NUM_CH(2), .OUT_WIDTH(16)) if_b ();
   pdm_mic_frontend #(.CLK_DIV(32), .DECIM(256), .OUT_WIDTH(16), .NUM_CH(2)) u_b (
      .clk_in(clk), .rst_in(rst_bc), .enable_in(en_b), .mic_data_in(data_b),
      .mic_clk_out(mclk_b), .pcm(if_b));

   // ---------------- DUT C: CLK_DIV=4, DECIM=4, OUT_WIDTH=8 ----------------
   logic en_c = 1'b0, c_data = 1'b0, mclk_c;
   pdm_mic_frontend_if #(.NUM_CH(1), .OUT_WIDTH(8)) if_c ();
   pdm_mic_frontend #(.CLK_DIV(4), .DECIM(4), .OUT_WIDTH(8), .NUM_CH(1)) u_c (
      .clk_in(clk), .rst_in(rst_bc), .enable_in(en_c), .mic_data_in(c_data),
      .mic_clk_out(mclk_c), .pcm(if_c));

   logic start_bc = 1'b0, b_done = 1'b0, c_done = 1'b0;

   // ---------------- A scoreboard ----------------
   logic [15:0] a_q[$];
   int a_ticks = 0, a_ref = 0, a_last = 0, a_first_tick = 0;
   bit a_first = 1'b0;

   always @(negedge clk) begin
      if (if_a.pdm_tick_out === 1'b1) begin
         a_ticks++;
         if (a_ticks == 1) a_first_tick = cyc - a_ref;
         a_alt = ~a_alt;
      end
      if (if_a.sample_valid_out === 1'b1) begin
         if (a_q.size() == 0)
            check("a_spurious_strobe", 64'(if_a.sample_valid_out), 64'(0));
         else begin
            check("a_sample", 64'(if_a.sample_out), 64'(a_q.pop_front()));
            if (a_first) check("a_first_latency", 64'(cyc - a_ref), 64'(8194));
            else         check("a_period", 64'(cyc - a_last), 64'(8192));
         end
         a_first = 1'b0;
         a_last  = cyc;
      end
   end

   task automatic start_a(input int mode);
      a_mode  = mode;
      a_alt   = 1'b1;
      a_ticks = 0;
      a_ref   = cyc;
      a_first = 1'b1;
      en_a    = 1'b1;
   endtask

   task automatic drain_a(input int bound);
      for (int i = 0; i < bound && a_q.size() != 0; i++) step();
      check("a_drain", 64'(a_q.size()), 64'(0));
   endtask

   task automatic wait_a_ticks(input int n);
      for (int i = 0; i < 8000 && a_ticks < n; i++) step();
      check("a_tick_wait", 64'(a_ticks >= n), 64'(1));
   endtask

   // ---------------- B scoreboard ----------------
   logic [31:0] b_q[$];
   always @(negedge clk) begin
      if (if_b.pdm_tick_out === 1'b1)
         check("b_bits", 64'(if_b.pdm_bits_out), 64'(2'b01));
      if (if_b.sample_valid_out === 1'b1) begin
         if (b_q.size() == 0)
            check("b_spurious_strobe", 64'(if_b.sample_valid_out), 64'(0));
         else
            check("b_sample", 64'(if_b.sample_out), 64'(b_q.pop_front()));
      end
   end

   initial begin : b_proc
      wait (start_bc);
      b_q.push_back({exp_a(0), exp_a(256)});
      b_q.push_back({exp_a(0), exp_a(256)});
      en_b = 1'b1;
      for (int i = 0; i < 20000 && b_q.size() != 0; i++) step();
      en_b = 1'b0;
      check("b_drain", 64'(b_q.size()), 64'(0));
      b_done = 1'b1;
   end

   // ---------------- C: reference model over driven bits ----------------
   localparam int C_BITS = 40;
   logic [7:0] c_q[$];
   int c_driven = 0, c_acc = 0, c_ticks = 0, c_last_ticks = 0;

   task automatic drive_c();
      int   f;
      logic b;
      f = c_driven / 4;
      b = (f == 0) ? 1'b1 : (f == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      c_data = b;
      c_acc += int'(b);
      c_driven++;
      if (c_driven % 4 == 0) begin
         c_q.push_back(exp_c(c_acc));
         c_acc = 0;
      end
   endtask

   initial begin : c_proc
      wait (start_bc);
      en_c = 1'b1;
      drive_c();
      for (int i = 0; i < 2000 && !(c_driven == C_BITS && c_q.size() == 0); i++) begin
         step();
         if (if_c.pdm_tick_out === 1'b1) begin
            c_ticks++;
            if (c_driven < C_BITS) drive_c();
         end
         if (if_c.sample_valid_out === 1'b1) begin
            if (c_q.size() == 0)
               check("c_spurious_strobe", 64'(if_c.sample_valid_out), 64'(0));
            else begin
               check("c_sample", 64'(if_c.sample_out), 64'(c_q.pop_front()));
               check("c_ticks_per_strobe", 64'(c_ticks - c_last_ticks), 64'(4));
            end
            c_last_ticks = c_ticks;
         end
      end
      en_c = 1'b0;
      check("c_drain", 64'(c_q.size()), 64'(0));
      c_done = 1'b1;
   end

   // ---------------- main sequence on A ----------------
   initial begin : main
      int rise1, fall1, rise2, d, pulses, highs;
      logic prev;
      repeat (4) step();
      check("rst_mclk",   64'(mclk_a), 64'(0));
      check("rst_tick",   64'(if_a.pdm_tick_out), 64'(0));
      check("rst_bits",   64'(if_a.pdm_bits_out), 64'(0));
      check("rst_valid",  64'(if_a.sample_valid_out), 64'(0));
      check("rst_sample", 64'(if_a.sample_out), 64'(0));
      check("rst_b_out",  64'(if_b.sample_out), 64'(0));
      check("rst_c_out",  64'(if_c.sample_out), 64'(0));
      rst_a  = 1'b0;
      rst_bc = 1'b0;
      step();
      start_bc = 1'b1;

      // constant ones: two frames, mic clock shape and first tick
      a_q.push_back(exp_a(256));
      a_q.push_back(exp_a(256));
      start_a(1);
      rise1 = -1; fall1 = -1; rise2 = -1; prev = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         d = cyc - a_ref;
         if (mclk_a && !prev) begin
            if (rise1 < 0) rise1 = d;
            else if (rise2 < 0) rise2 = d;
         end
         if (!mclk_a && prev && fall1 < 0) fall1 = d;
         prev = mclk_a;
      end
      check("mclk_rise",   64'(rise1), 64'(1));
      check("mclk_fall",   64'(fall1), 64'(17));
      check("mclk_rise2",  64'(rise2), 64'(33));
      check("first_tick",  64'(a_first_tick), 64'(33));
      drain_a(20000);
      en_a = 1'b0;
      step();

      // alternating bits
      a_q.push_back(exp_a(128));
      start_a(2);
      drain_a(9000);
      en_a = 1'b0;
      step();

      // constant zeros
      a_q.push_back(exp_a(0));
      start_a(0);
      drain_a(9000);
      en_a = 1'b0;
      step();

      // disable mid-frame, then re-enable
      start_a(1);
      wait_a_ticks(100);
      en_a = 1'b0;
      pulses = 0; highs = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (if_a.pdm_tick_out === 1'b1 || if_a.sample_valid_out === 1'b1) pulses++;
         if (mclk_a !== 1'b0) highs++;
      end
      check("dis_pulses", 64'(pulses), 64'(0));
      check("dis_mclk",   64'(highs), 64'(0));
      check("dis_hold",   64'(if_a.sample_out), 64'(exp_a(0)));
      a_q.push_back(exp_a(256));
      start_a(1);
      drain_a(9000);

      // reset mid-frame with enable held
      a_ticks = 0;
      wait_a_ticks(100);
      check("pre_rst_hold", 64'(if_a.sample_out), 64'(exp_a(256)));
      rst_a = 1'b1;
      step();
      check("rst_mid_sample", 64'(if_a.sample_out), 64'(0));
      check("rst_mid_mclk",   64'(mclk_a), 64'(0));
      check("rst_mid_valid",  64'(if_a.sample_valid_out), 64'(0));
      a_q.push_back(exp_a(256));
      a_ticks = 0;
      a_ref   = cyc;
      a_first = 1'b1;
      rst_a   = 1'b0;
      drain_a(9000);
      en_a = 1'b0;

      for (int i = 0; i < 20000 && !(b_done && c_done); i++) step();
      check("bc_done", 64'({b_done, c_done}), 64'(2'b11));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
